// File: rtl/tow_pkg.sv
// Shared types for the tug-of-war game: match phases, winner codes, score helper.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package tow_pkg;

   typedef enum logic [2:0] {
      PH_IDLE       = 3'd0,
      PH_COUNTDOWN  = 3'd1,
      PH_PLAY       = 3'd2,
      PH_ROUND_END  = 3'd3,
      PH_MATCH_OVER = 3'd4
   } phase_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_L    = 2'b10;
   localparam logic [1:0] WIN_R    = 2'b01;

   // Scores stop at 15 rather than wrapping back to 0.
   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/match_ctrl_tick_gen.sv
// Free-running step counter: emits a one-cycle tick every PERIOD clocks.
// Latency: tick asserts PERIOD cycles after the last clear (or reset).
// Backpressure: none; clr restarts the count so the next step is full length.
module tick_gen #(
   parameter int PERIOD = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Restart on clear, otherwise count up and wrap after the last value.
   always_comb begin
      if (clr || (cnt_q == LAST)) cnt_d = '0;
      else                        cnt_d = cnt_q + CW'(1);
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/match_ctrl.sv
// Tug-of-war round/match sequencer: countdown, press gating, round and match scoring.
// Latency: presses reach l_move/r_move one cycle later; every output is a flop.
// Backpressure: none; presses outside PLAY, cancelled or on a scoring cycle are dropped.
module match_ctrl
   import tow_pkg::*;
#(
   parameter int WINS_TO_MATCH = 3,
   parameter int TICK_CYCLES   = 50_000_000,
   parameter int COUNT_STEPS   = 3,
   parameter int HOLD_STEPS    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       l_press,
   input  logic       r_press,
   input  logic       l_edge,
   input  logic       r_edge,
   output logic       l_move,
   output logic       r_move,
   output logic       field_clear,
   output logic [1:0] count_val,
   output logic [3:0] l_score,
   output logic [3:0] r_score,
   output logic [2:0] phase,
   output logic [1:0] match_winner
);

   localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

   phase_t          phase_q, phase_d;
   logic [1:0]      count_q, count_d;
   logic [1:0]      win_q, win_d;
   logic [3:0]      lsc_q, lsc_d, rsc_q, rsc_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic            lmv_q, lmv_d, rmv_q, rmv_d, clr_q, clr_d;
   logic            won_l_q, won_l_d;
   logic            tick, tick_clr;
   logic            edge_l_win, edge_r_win, hold_done, match_done;

   // Exactly one edge lit decides a round; both lit is a field fault and is ignored.
   assign edge_l_win = l_edge & ~r_edge;
   assign edge_r_win = r_edge & ~l_edge;
   assign hold_done  = tick && (hold_q == HW'(HOLD_STEPS - 1));
   assign match_done = won_l_q ? (lsc_q == 4'(WINS_TO_MATCH)) : (rsc_q == 4'(WINS_TO_MATCH));
   // Every phase change restarts the step counter so each first step is full length.
   assign tick_clr   = (phase_d != phase_q);

   tick_gen #(.PERIOD(TICK_CYCLES)) u_tick (
      .clk   (clk),
      .reset (reset),
      .clr   (tick_clr),
      .tick  (tick)
   );

   // Phase register.
   always_ff @(posedge clk) begin
      if (reset) phase_q <= PH_IDLE;
      else       phase_q <= phase_d;
   end

   // Phase transitions.
   always_comb begin
      phase_d = phase_q;
      case (phase_q)
         PH_IDLE, PH_MATCH_OVER: if (start) phase_d = PH_COUNTDOWN;
         PH_COUNTDOWN:           if (tick && (count_q == 2'd1)) phase_d = PH_PLAY;
         PH_PLAY:                if (edge_l_win || edge_r_win) phase_d = PH_ROUND_END;
         PH_ROUND_END:           if (hold_done) phase_d = match_done ? PH_MATCH_OVER : PH_COUNTDOWN;
         default:                phase_d = PH_IDLE;
      endcase
   end

   // Next values of the output and bookkeeping registers.
   always_comb begin
      count_d = '0;
      win_d   = win_q;
      lsc_d   = lsc_q;
      rsc_d   = rsc_q;
      hold_d  = hold_q;
      won_l_d = won_l_q;
      lmv_d   = 1'b0;
      rmv_d   = 1'b0;
      clr_d   = 1'b0;
      case (phase_q)
         PH_IDLE, PH_MATCH_OVER: begin
            if (start) begin
               lsc_d = '0;
               rsc_d = '0;
               win_d = WIN_NONE;
               clr_d = 1'b1;
            end
         end
         PH_COUNTDOWN: begin
            count_d = tick ? count_q - 2'd1 : count_q;
         end
         PH_PLAY: begin
            hold_d = '0;
            if (edge_l_win) begin
               lsc_d   = sat_inc(lsc_q);
               won_l_d = 1'b1;
            end else if (edge_r_win) begin
               rsc_d   = sat_inc(rsc_q);
               won_l_d = 1'b0;
            end else begin
               // Simultaneous presses cancel each other.
               lmv_d = l_press & ~r_press;
               rmv_d = r_press & ~l_press;
            end
         end
         PH_ROUND_END: begin
            if (tick) hold_d = hold_q + HW'(1);
            if (hold_done) begin
               if (match_done) win_d = won_l_q ? WIN_L : WIN_R;
               else            clr_d = 1'b1;
            end
         end
         default: ;
      endcase
      // Each countdown begins from the top digit.
      if ((phase_q != PH_COUNTDOWN) && (phase_d == PH_COUNTDOWN)) count_d = 2'(COUNT_STEPS);
   end

   // Output and bookkeeping registers; reset also recentres the field once.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         win_q   <= WIN_NONE;
         lsc_q   <= '0;
         rsc_q   <= '0;
         hold_q  <= '0;
         won_l_q <= 1'b0;
         lmv_q   <= 1'b0;
         rmv_q   <= 1'b0;
         clr_q   <= 1'b1;
      end else begin
         count_q <= count_d;
         win_q   <= win_d;
         lsc_q   <= lsc_d;
         rsc_q   <= rsc_d;
         hold_q  <= hold_d;
         won_l_q <= won_l_d;
         lmv_q   <= lmv_d;
         rmv_q   <= rmv_d;
         clr_q   <= clr_d;
      end
   end

   assign l_move       = lmv_q;
   assign r_move       = rmv_q;
   assign field_clear  = clr_q;
   assign count_val    = count_q;
   assign l_score      = lsc_q;
   assign r_score      = rsc_q;
   assign phase        = phase_q;
   assign match_winner = win_q;

endmodule
